// File: rtl/simple_bit_unpack_loader_if.sv
// ---------------------------------------------------------------------------
// simple_bit_unpack_loader_if
//   Bundles the byte-stream input handshake and the assembled-vector output
//   handshake of the simpleBitUnpack loader.
//
//   Parameter B is the coefficient bound; the vector width follows from it
//   exactly as in the loader (32 * bitlen(B) bytes).
//
//   Signals:
//     in_data   [7:0]          encoded byte
//     in_valid                 in_data / in_last valid
//     in_last                  final byte of a frame
//     in_ready                 loader accepts a byte this cycle
//     v_out     [TOTAL_BITS-1] assembled vector for the unpacker v input
//     out_valid                v_out holds a complete, well-formed frame
//     out_ready                consumer takes v_out this cycle
//     frame_err                one-cycle pulse on a malformed frame
//
//   Modports:
//     master : the surrounding system (drives bytes, consumes the vector)
//     slave  : the loader itself
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface simple_bit_unpack_loader_if #(
  parameter int B = 1023
);
  localparam int C          = (B == 0) ? 1 : $clog2(B + 1);
  localparam int TOTAL_BITS = 256 * C;

  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [TOTAL_BITS-1:0] v_out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  frame_err;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, v_out, out_valid, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, v_out, out_valid, frame_err
  );
endinterface

// File: rtl/simple_bit_unpack_loader.sv
// ---------------------------------------------------------------------------
// simple_bit_unpack_loader
//   Upstream feeder for simpleBitUnpack in the ML-DSA decode path. Collects an
//   encoded polynomial arriving as a byte stream (valid/ready/last) into the
//   flat 32*bitlen(B)-byte vector, little-endian: byte k lands in
//   v_out[k*8 +: 8]. Frames of the wrong length raise a one-cycle frame_err
//   and are never presented downstream.
//
//   Ports:
//     clk    : clock, everything on the rising edge
//     reset  : asynchronous, active-high reset
//     bus    : simple_bit_unpack_loader_if.slave
//              (in_data/in_valid/in_last/in_ready byte input,
//               v_out/out_valid/out_ready vector output, frame_err)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module simple_bit_unpack_loader #(
  parameter int B = 1023
) (
  input  logic                        clk,
  input  logic                        reset,
  simple_bit_unpack_loader_if.slave   bus
);

  localparam int C           = (B == 0) ? 1 : $clog2(B + 1);
  localparam int TOTAL_BYTES = 32 * C;
  localparam int TOTAL_BITS  = 8 * TOTAL_BYTES;
  localparam int CNT_W       = $clog2(TOTAL_BYTES + 1);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_BYTES - 1);

  // FILL  : collecting bytes of a frame
  // FULL  : complete frame on v_out, waiting for the consumer
  // DRAIN : over-long frame detected, discarding bytes up to in_last
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TOTAL_BITS-1:0] v_out_q, v_out_d;
  logic                  frame_err_q, frame_err_d;

  logic                  in_ready;
  logic                  in_fire;
  logic                  wr_en;

  assign in_ready = (state_q == FILL) || (state_q == DRAIN);
  assign in_fire  = bus.in_valid && in_ready;

  // Next-state / control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      FILL: begin
        if (in_fire) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
            if (bus.in_last) begin
              wr_en   = 1'b1;
              state_d = FULL;
            end else begin
              // Byte TOTAL_BYTES would overflow the vector: flag once here,
              // then swallow the rest of the frame silently.
              frame_err_d = 1'b1;
              state_d     = DRAIN;
            end
          end else if (bus.in_last) begin
            // Short frame: the terminating byte is dropped, not written.
            frame_err_d = 1'b1;
            cnt_d       = '0;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      FULL: begin
        if (bus.out_ready) begin
          state_d = FILL;
        end
      end

      DRAIN: begin
        if (in_fire && bus.in_last) begin
          state_d = FILL;
        end
      end

      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  // Byte-lane write decode: only the lane addressed by cnt_q is updated, every
  // other lane holds its (possibly stale) contents.
  for (genvar gi = 0; gi < TOTAL_BYTES; gi++) begin : g_lane
    assign v_out_d[gi*8 +: 8] = (wr_en && (cnt_q == CNT_W'(gi)))
                                ? bus.in_data
                                : v_out_q[gi*8 +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      v_out_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      v_out_q     <= v_out_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.v_out     = v_out_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_simple_bit_unpack_loader.sv
`timescale 1ns/1ps
module tb_simple_bit_unpack_loader;

  localparam int B           = 1023;
  localparam int C           = 10;
  localparam int TOTAL_BYTES = 32 * C;
  localparam int TOTAL_BITS  = 8 * TOTAL_BYTES;

  logic clk = 1'b0;
  logic reset;

  simple_bit_unpack_loader_if #(.B(B)) bus ();

  simple_bit_unpack_loader #(.B(B)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks   = 0;
  int n_fail     = 0;
  int err_exp    = 0;
  int err_seen   = 0;
  int good_sent  = 0;
  int frames_out = 0;

  logic [TOTAL_BITS-1:0] exp_q[$];
  logic [TOTAL_BITS-1:0] exp_v;
  logic [TOTAL_BITS-1:0] ramp_v;
  logic [7:0]            frm[$];
  bit                    rand_ready_en = 1'b0;

  task automatic report_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [TOTAL_BITS-1:0] act,
                           input logic [TOTAL_BITS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      for (int i = 0; i < TOTAL_BYTES; i++) begin
        if (act[i*8 +: 8] !== exp[i*8 +: 8]) begin
          $display("FAIL %s: first differing byte %0d got 0x%02h, expected 0x%02h",
                   name, i, act[i*8 +: 8], exp[i*8 +: 8]);
          break;
        end
      end
    end
  endtask

  // Scoreboard monitor: every output transfer must match the oldest expected
  // frame; frame_err pulses are tallied for a final count comparison.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.frame_err) err_seen++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: got an output transfer, expected none");
        end else begin
          exp_v = exp_q.pop_front();
          check_vec("frame_data", bus.v_out, exp_v);
          frames_out++;
          $display("frame %0d delivered, first byte 0x%02h", frames_out, bus.v_out[7:0]);
        end
      end
    end
  end

  // Random consumer back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready_en) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Absolute time guard.
  initial begin
    #2_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got simulation still running, expected completion");
    report_and_finish();
  end

  // Offers one byte and returns just after the edge on which it transferred.
  task automatic send_byte(input logic [7:0] d, input logic last);
    bit ok;
    int budget;
    ok     = 1'b0;
    budget = 2000;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    while (budget > 0) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      budget--;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_timeout: got in_ready=0 for 2000 cycles, expected 1");
      report_and_finish();
    end
  endtask

  // Reference model: a frame is good iff it has exactly TOTAL_BYTES bytes, in
  // which case the vector is the bytes laid out little-endian. Otherwise one
  // error pulse is expected: on the last byte of a short frame, or on byte
  // TOTAL_BYTES-1 of a long one.
  task automatic send_frame(input logic [7:0] bytes[$], input int gap_pct);
    int len;
    logic [TOTAL_BITS-1:0] v;
    bit last;
    bit exp_err;
    len = bytes.size();
    if (len == TOTAL_BYTES) begin
      v = '0;
      for (int k = 0; k < len; k++) v[k*8 +: 8] = bytes[k];
      exp_q.push_back(v);
      good_sent++;
    end else begin
      err_exp++;
    end
    for (int k = 0; k < len; k++) begin
      for (int g = 0; g < 4 && gap_pct > 0; g++) begin
        if ($urandom_range(0, 99) >= gap_pct) break;
        @(posedge clk);
        #1;
      end
      last = (k == len - 1);
      send_byte(bytes[k], last);
      exp_err = (len < TOTAL_BYTES && last) || (len > TOTAL_BYTES && k == TOTAL_BYTES - 1);
      check("frame_err", 64'(bus.frame_err), 64'(exp_err));
      if (len == TOTAL_BYTES && last)
        check("out_valid_latency", 64'(bus.out_valid), 64'd1);
    end
    $display("frame sent: %0d bytes, expected %s", len, (len == TOTAL_BYTES) ? "good" : "error");
  endtask

  task automatic wait_drain();
    int budget;
    budget = 3000;
    while ((exp_q.size() != 0 || bus.out_valid) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic make_random(input int len);
    frm.delete();
    for (int k = 0; k < len; k++) frm.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_frame_err", 64'(bus.frame_err), 64'd0);
    check_vec("reset_v_out", bus.v_out, '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Ramp frame, back-to-back, consumer always ready.
    bus.out_ready = 1'b1;
    frm.delete();
    for (int k = 0; k < TOTAL_BYTES; k++) frm.push_back(8'(k % 256));
    ramp_v = '0;
    for (int k = 0; k < TOTAL_BYTES; k++) ramp_v[k*8 +: 8] = 8'(k % 256);
    send_frame(frm, 0);
    check("ramp_byte0", 64'(bus.v_out[7:0]), 64'h00);
    check("ramp_byte1", 64'(bus.v_out[15:8]), 64'h01);
    check("ramp_byte319", 64'(bus.v_out[TOTAL_BITS-1 -: 8]), 64'h3F);
    check("ramp_w0", 64'(bus.v_out[C-1:0]), 64'd256);
    check("ramp_w1", 64'(bus.v_out[2*C-1:C]), 64'd128);
    check("ramp_in_ready_full", 64'(bus.in_ready), 64'd0);
    wait_drain();

    // Same frame held by a stalled consumer while upstream keeps pushing junk.
    bus.out_ready = 1'b0;
    send_frame(frm, 0);
    for (int i = 0; i < 50; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom_range(0, 255));
      bus.in_last  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check_vec("hold_v_out", bus.v_out, ramp_v);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    check("release_out_valid", 64'(bus.out_valid), 64'd0);

    // Short frame (last on byte 100) then an all-0xA5 frame.
    make_random(101);
    send_frame(frm, 0);
    frm.delete();
    for (int k = 0; k < TOTAL_BYTES; k++) frm.push_back(8'hA5);
    send_frame(frm, 0);
    wait_drain();

    // Long frame of 330 bytes then a good random frame.
    make_random(330);
    send_frame(frm, 0);
    make_random(TOTAL_BYTES);
    send_frame(frm, 0);
    wait_drain();

    // Random input gaps and random back-pressure over 20 frames.
    rand_ready_en = 1'b1;
    for (int f = 0; f < 20; f++) begin
      make_random(TOTAL_BYTES);
      send_frame(frm, 40);
    end
    rand_ready_en = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    wait_drain();

    // Asynchronous reset in the middle of a frame.
    for (int k = 0; k < 200; k++) send_byte(8'($urandom_range(1, 255)), 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_vec("async_reset_v_out", bus.v_out, '0);
    check("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_reset_frame_err", 64'(bus.frame_err), 64'd0);
    check("async_reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    make_random(TOTAL_BYTES);
    send_frame(frm, 0);
    wait_drain();

    repeat (5) @(posedge clk);
    #1;
    check("frame_err_count", 64'(err_seen), 64'(err_exp));
    check("frame_count", 64'(frames_out), 64'(good_sent));
    report_and_finish();
  end

endmodule

// File: doc/simple_bit_unpack_loader.md
Name: simple_bit_unpack_loader

Overview:
- Upstream feeder for the simpleBitUnpack stage in the ML-DSA decode path.
- Accepts an encoded polynomial as a byte stream using a valid/ready/last handshake.
- Assembles the bytes into the flat 32*bitlen(B)-byte vector that the unpacker consumes on its v input.
- Presents the vector with a valid/ready handshake and flags malformed frames (wrong byte count).

Parameters:
- B, 1023, coefficient bound. C = bitlen(B) = (B==0) ? 1 : $clog2(B+1). Default gives C=10.
- TOTAL_BYTES, derived (localparam) = 32*C. Bytes per frame; default 320.
- TOTAL_BITS, derived (localparam) = 8*TOTAL_BYTES. Default 2560.
- CNT_W, derived (localparam) = $clog2(TOTAL_BYTES+1). Byte counter width.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- in_data  input  8  encoded byte
- in_valid  input  1  in_data/in_last valid
- in_last  input  1  marks the final byte of a frame
- in_ready  output  1  loader can accept a byte this cycle
- v_out  output  TOTAL_BITS  assembled vector; drives simpleBitUnpack v
- out_valid  output  1  v_out holds a complete, well-formed frame
- out_ready  input  1  consumer takes v_out this cycle
- frame_err  output  1  one-cycle pulse on a malformed frame

Behaviour:
- Reset (async, active-high): state=FILL, cnt=0, v_out=0, out_valid=0, frame_err=0. Reset mid-frame discards all partial data.
- Byte placement: the k-th accepted byte of a frame (k=0 first) is written to v_out[k*8 +: 8]. This is little-endian, with no bit reversal within a byte, so coefficient i = v_out[i*C +: C].
- Bytes not yet written in the current frame keep stale contents. This is not observable because out_valid=0 until the frame is complete.
- Handshake: a byte transfers when in_valid && in_ready. The output transfers when out_valid && out_ready.
- FILL state (in_ready=1, out_valid=0), on each transfer:
  - cnt < TOTAL_BYTES-1 and in_last=0: write the byte, cnt++.
  - cnt < TOTAL_BYTES-1 and in_last=1 (short frame): frame_err pulses next cycle, cnt=0, stay in FILL. The byte is discarded.
  - cnt == TOTAL_BYTES-1 and in_last=1: write the byte, cnt=0, go to FULL. out_valid=1 from the next cycle.
  - cnt == TOTAL_BYTES-1 and in_last=0 (long frame): write nothing, frame_err pulses next cycle, cnt=0, go to DRAIN.
- FULL state: in_ready=0, out_valid=1, v_out held stable. When out_ready=1, out_valid=0 next cycle and go to FILL.
  - There is no same-cycle refill bypass, so in_ready is low for the whole cycle in which out_ready is seen.
- DRAIN state: in_ready=1, out_valid=0. Transferred bytes are discarded. A transfer with in_last=1 returns to FILL with cnt=0. Any pulse of frame_err occurs only once per bad frame.
- in_valid is ignored whenever in_ready=0. The upstream source must hold its byte until it is accepted.
- out_valid never drops without out_ready. v_out does not change while out_valid=1.
- Latency: the last byte is accepted in cycle t and out_valid=1 in cycle t+1. Minimum frame period is TOTAL_BYTES+1 cycles with out_ready tied high.
- Registers: cnt (CNT_W bits), 2-bit state, v_out register, frame_err register. All are asynchronously reset.

Test Plan (B=1023, C=10, TOTAL_BYTES=320):
- Byte k = k mod 256 streamed back-to-back, in_last on k=319, out_ready=1:
  - out_valid rises exactly 1 cycle after byte 319.
  - v_out[7:0]=0x00, v_out[15:8]=0x01, v_out[2559:2552]=0x3F.
  - Downstream coefficients: w[0]=256, w[1]=128.
- Same frame with out_ready=0 for 50 cycles:
  - out_valid stays 1, in_ready stays 0, v_out is unchanged.
  - Upstream in_valid is ignored.
  - On out_ready=1, in_ready returns 1 the next cycle.
- Short frame with in_last on byte 100:
  - frame_err pulses once, no out_valid.
  - A following correct 320-byte frame of all 0xA5 yields v_out equal to all 0xA5.
- Long frame of 330 bytes with in_last on byte 329:
  - frame_err pulses once, after byte 319.
  - Bytes 320..329 are discarded and no out_valid occurs.
  - The next good frame is assembled correctly.
- Random in_valid gaps (~40% duty) and random out_ready over 20 frames: the v_out of every frame matches a reference model; no frames are lost or duplicated.
- reset asserted asynchronously after byte 200:
  - outputs go to zero immediately.
  - After release, a fresh 320-byte frame is assembled correctly.
